// File: rtl/pcie_ram_loader.sv
`default_nettype none
// ============================================================================
// pcie_ram_loader : unpacks PCIe beats into 16-bit RAM writes at a base address.
// Optional LOADER_CHECKSUM_EN adds a running 16-bit sum of written words.
// Revision: 1.0
// ============================================================================
module pcie_ram_loader #(
  parameter int PCIE_DATA_WIDTH = 64,
  parameter int ADDR_WIDTH      = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [ADDR_WIDTH-1:0]      base_addr,
  input  logic [15:0]                load_len,
  input  logic [PCIE_DATA_WIDTH-1:0] pcie_data,
  input  logic                       pcie_valid,
  output logic                       pcie_ready,
  output logic                       ram_en,
  output logic                       ram_we,
  output logic [ADDR_WIDTH-1:0]      ram_addr,
  output logic [15:0]                ram_din,
  output logic                       busy,
  output logic                       complete
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [15:0]                checksum
`endif
);

  localparam int WPB   = PCIE_DATA_WIDTH / 16;
  localparam int CNT_W = $clog2(WPB + 1);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WPB);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RECV   = 2'd1;
  localparam logic [1:0] S_UNPACK = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]                 state;
  logic [ADDR_WIDTH-1:0]      addr;
  logic [15:0]                remaining;
  logic [PCIE_DATA_WIDTH-1:0] beat;
  logic [CNT_W-1:0]           word_cnt;
  logic                       write_en;
  logic                       take_beat;
  logic                       next_word;
  logic                       write_next;
  logic [15:0]                word;

  assign pcie_ready = (state == S_RECV);
  assign busy       = (state == S_RECV) || (state == S_UNPACK);
  assign ram_en     = write_en;
  assign ram_we     = write_en;

  // Word 0 is issued on the acceptance edge so the first write lands the cycle after.
  assign take_beat  = pcie_ready && pcie_valid;
  assign next_word  = (state == S_UNPACK) && (remaining != 16'd0) && (word_cnt != LAST_WORD);
  assign write_next = take_beat || next_word;
  assign word       = take_beat ? pcie_data[15:0] : beat[15:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      addr      <= '0;
      remaining <= '0;
      beat      <= '0;
      word_cnt  <= '0;
      write_en  <= 1'b0;
      ram_addr  <= '0;
      ram_din   <= '0;
      complete  <= 1'b0;
    end else begin
      write_en <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            addr      <= base_addr;
            remaining <= load_len;
            complete  <= (load_len == 16'd0);
            state     <= (load_len == 16'd0) ? S_DONE : S_RECV;
          end
        end
        S_RECV: begin
          if (pcie_valid) begin
            beat     <= pcie_data >> 16;
            word_cnt <= CNT_W'(1);
            state    <= S_UNPACK;
          end
        end
        S_UNPACK: begin
          if (remaining == 16'd0) begin
            state    <= S_DONE;
            complete <= 1'b1;
          end else if (word_cnt == LAST_WORD) begin
            state <= S_RECV;
          end else begin
            beat     <= beat >> 16;
            word_cnt <= word_cnt + CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase

      if (write_next) begin
        write_en  <= 1'b1;
        ram_addr  <= addr;
        ram_din   <= word;
        addr      <= addr + ADDR_WIDTH'(1);
        remaining <= remaining - 16'd1;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic start_ok;
  assign start_ok = start && ((state == S_IDLE) || (state == S_DONE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      checksum <= '0;
    end else if (start_ok) begin
      checksum <= '0;
    end else if (write_next) begin
      checksum <= checksum + word;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pcie_ram_loader.sv
`default_nettype none
// Bench for pcie_ram_loader: randomized loads checked against a word-list RAM model.
module tb_pcie_ram_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] base_addr;
  logic [15:0] load_len;
  logic [63:0] pcie_data;
  logic        pcie_valid;
  logic        pcie_ready;
  logic        ram_en;
  logic        ram_we;
  logic [15:0] ram_addr;
  logic [15:0] ram_din;
  logic        busy;
  logic        complete;
`ifdef LOADER_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int we_bad   = 0;
  logic [31:0] wlog[$];
  logic [63:0] beats_q[$];

  pcie_ram_loader #(.PCIE_DATA_WIDTH(64), .ADDR_WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .load_len   (load_len),
    .pcie_data  (pcie_data),
    .pcie_valid (pcie_valid),
    .pcie_ready (pcie_ready),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .busy       (busy),
    .complete   (complete)
`ifdef LOADER_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ram_en === 1'b1) wlog.push_back({ram_addr, ram_din});
    if (ram_en !== ram_we) we_bad++;
  end

  task automatic check(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s/%s: observed 0x%0h expected 0x%0h", tag, what, obs, exp);
    end
  endtask

  task automatic fill_beats(input int n);
    beats_q.delete();
    for (int i = 0; i < n; i++) beats_q.push_back({$urandom, $urandom});
  endtask

  // Word i of the load goes to base+i and is 16-bit lane i%4 of beat i/4.
  function automatic logic [31:0] exp_entry(input logic [15:0] base, input int i);
    logic [63:0] b;
    logic [15:0] w;
    logic [15:0] a;
    b = beats_q[i / 4];
    w = b[16 * (i % 4) +: 16];
    a = base + 16'(i);
    return {a, w};
  endfunction

  task automatic do_load(input string tag, input logic [15:0] base, input logic [15:0] len,
                         input bit rv, input bit extra_start, input int abort_after, output int cyc);
    int nbeats;
    int bi;
    int n_rst;
    bit hs;
    logic [15:0] sum;
    logic [31:0] e;
    nbeats = (int'(len) + 3) / 4;
    while (beats_q.size() < nbeats + 1) beats_q.push_back({$urandom, $urandom});
    bi = 0;
    wlog.delete();
    we_bad     = 0;
    base_addr  = base;
    load_len   = len;
    start      = 1'b1;
    pcie_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (complete !== 1'b1 && cyc < 600) begin
      if (abort_after > 0 && wlog.size() >= abort_after) begin
        n_rst = wlog.size();
        rst = 1'b1;
        #1;
        check(tag, "ram_we at rst", ram_we, 0);
        check(tag, "busy at rst", busy, 0);
        check(tag, "complete at rst", complete, 0);
        check(tag, "ready at rst", pcie_ready, 0);
        check(tag, "ram_addr at rst", ram_addr, 0);
        pcie_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check(tag, "no write after rst", wlog.size(), n_rst);
        for (int i = 0; i < n_rst && i < int'(len); i++) check(tag, "prefix word", wlog[i], exp_entry(base, i));
        return;
      end
      start = extra_start && (cyc == 4);
      if (start) begin
        base_addr = 16'($urandom);
        load_len  = 16'($urandom);
      end
      pcie_valid = (bi <= nbeats) && (!rv || $urandom_range(0, 1) == 1);
      pcie_data  = (bi <= nbeats) ? beats_q[bi] : 64'h0;
      hs = pcie_valid && pcie_ready;
      @(posedge clk); #1;
      if (hs) bi++;
      cyc++;
    end
    start = 1'b0;
    check(tag, "complete", complete, 1);
    check(tag, "writes at complete", wlog.size(), len);
    pcie_valid = 1'b1;
    pcie_data  = {$urandom, $urandom};
    repeat (3) begin
      check(tag, "ready after done", pcie_ready, 0);
      @(posedge clk); #1;
    end
    pcie_valid = 1'b0;
    check(tag, "busy after done", busy, 0);
    check(tag, "complete holds", complete, 1);
    check(tag, "beats consumed", bi, nbeats);
    check(tag, "ram_we==ram_en", we_bad, 0);
    check(tag, "write count", wlog.size(), len);
    sum = 16'h0;
    for (int i = 0; i < int'(len); i++) begin
      e = exp_entry(base, i);
      sum = sum + e[15:0];
      if (i < wlog.size()) check(tag, "write word", wlog[i], e);
    end
`ifdef LOADER_CHECKSUM_EN
    check(tag, "checksum", checksum, sum);
`endif
  endtask

  initial begin
    int cyc;
    logic [31:0] e;
    rst        = 1'b1;
    start      = 1'b0;
    base_addr  = 16'h0;
    load_len   = 16'h0;
    pcie_data  = 64'h0;
    pcie_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset", "pcie_ready", pcie_ready, 0);
    check("reset", "ram_en", ram_en, 0);
    check("reset", "ram_we", ram_we, 0);
    check("reset", "busy", busy, 0);
    check("reset", "complete", complete, 0);
    check("reset", "ram_addr", ram_addr, 0);
    check("reset", "ram_din", ram_din, 0);
`ifdef LOADER_CHECKSUM_EN
    check("reset", "checksum", checksum, 0);
`endif
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    beats_q.delete();
    beats_q.push_back(64'h0004_0003_0002_0001);
    beats_q.push_back(64'h0008_0007_0006_0005);
    beats_q.push_back(64'h00FF_00FF_00FF_00FF);
    do_load("basic", 16'h0010, 16'd8, 1'b0, 1'b0, 0, cyc);
    if (wlog.size() == 8) begin
      check("basic", "first write", wlog[0], 32'h0010_0001);
      check("basic", "last write", wlog[7], 32'h0017_0008);
    end
`ifdef LOADER_CHECKSUM_EN
    check("basic", "checksum 0x24", checksum, 16'h0024);
`endif

    fill_beats(3);
    do_load("len5", 16'($urandom), 16'd5, 1'b0, 1'b0, 0, cyc);

    fill_beats(2);
    do_load("wrap", 16'hFFFE, 16'd4, 1'b0, 1'b0, 0, cyc);
    if (wlog.size() == 4) begin
      e = wlog[2];
      check("wrap", "third addr", e[31:16], 16'h0000);
    end

    fill_beats(1);
    do_load("len0", 16'($urandom), 16'd0, 1'b0, 1'b0, 0, cyc);
    check("len0", "cycles to complete", cyc, 0);

    fill_beats(5);
    do_load("rvalid_start", 16'($urandom), 16'd16, 1'b1, 1'b1, 0, cyc);

    for (int k = 0; k < 6; k++) begin
      fill_beats(6);
      do_load("random", 16'($urandom), 16'($urandom_range(1, 20)), 1'b1, 1'b0, 0, cyc);
    end

    fill_beats(5);
    do_load("abort", 16'($urandom), 16'd16, 1'b0, 1'b0, 3, cyc);
    fill_beats(5);
    do_load("after_abort", 16'($urandom), 16'd16, 1'b1, 1'b0, 0, cyc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
